audio_uart_tx_arb: RTL and testbench

Parametrised fabric-side UART transmitter that merges byte streams from up to NUM_CH fabric sources onto one serial line toward the audio playback module. Each channel has its own byte FIFO. A round-robin arbiter grants whole packets delimited by a LAST flag, and a configurable serialiser drives TXD with programmable baud divider, parity and stop bits. It sits beside the MSS in the audio descriptor top level and frees the MSS UARTs for host traffic.

---
 rtl/audio_uart_pkg.sv | 24 ++
 rtl/audio_byte_fifo.sv | 52 +++++
 rtl/audio_uart_tx_arb.sv | 184 ++++++++++++++++++
 tb/tb_audio_uart_tx_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_uart_pkg.sv
// Shared constants for the fabric-side audio UART transmitter: parity modes,
// serialiser state encoding and the FIFO entry layout {last, byte}.
package audio_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int ENTRY_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Line level of the parity bit for a byte; even mode is the XOR of the bits.
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/audio_byte_fifo.sv
// Single-clock FIFO with a combinational head read (first word fall-through).
// A push while full is ignored, so push and pop on a full FIFO cannot coincide.
module audio_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array carries no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/audio_uart_tx_arb.sv
// Multi-channel UART transmitter: per-channel byte FIFOs, a packet-granular
// round-robin arbiter and a single serialiser driving TXD.
module audio_uart_tx_arb
  import audio_uart_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 4167,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  FAB_CLK,
  input  logic                  MSS_RESET_N,
  input  logic [NUM_CH-1:0]     WR_EN,
  input  logic [8*NUM_CH-1:0]   WR_DATA,
  input  logic [NUM_CH-1:0]     WR_LAST,
  output logic [NUM_CH-1:0]     FULL,
  output logic [NUM_CH-1:0]     OVF,
  input  logic [NUM_CH-1:0]     OVF_CLR,
  output logic                  TXD,
  output logic                  BUSY,
  output logic [GW-1:0]         GRANT
);

  localparam int            BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  logic [NUM_CH-1:0]  fifo_full;
  logic [NUM_CH-1:0]  fifo_empty;
  logic [NUM_CH-1:0]  pop_vec;
  logic [ENTRY_W-1:0] fifo_head [NUM_CH];
  logic [ENTRY_W-1:0] head;

  tx_state_e          state_q;
  tx_state_e          state_nxt;
  logic [BW-1:0]      baud_q;
  logic [2:0]         bit_q;
  logic [GW-1:0]      grant_q;
  logic [GW-1:0]      scan_ch;
  logic [GW-1:0]      pop_ch;
  logic               held_q;
  logic               pend_q;
  logic               last_q;
  logic               txd_q;
  logic               txd_nxt;
  logic               par_q;
  logic [7:0]         shift_q;
  logic [NUM_CH-1:0]  ovf_q;

  logic               scan_found;
  logic               baud_end;
  logic               frame_done;
  logic               arb_free;
  logic               start_new;
  logic               cont;
  logic               do_pop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    audio_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk     (FAB_CLK),
      .rst_n   (MSS_RESET_N),
      .push    (WR_EN[c]),
      .wr_data ({WR_LAST[c], WR_DATA[8*c +: 8]}),
      .pop     (pop_vec[c]),
      .rd_data (fifo_head[c]),
      .full    (fifo_full[c]),
      .empty   (fifo_empty[c])
    );
  end

  // Sticky overflow flags; a refused write beats a clear in the same cycle.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) ovf_q <= '0;
    else              ovf_q <= (ovf_q & ~OVF_CLR) | (WR_EN & fifo_full);
  end

  // Round-robin scan starting one past the current/last grant.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = grant_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!scan_found && !fifo_empty[(int'(grant_q) + i) % NUM_CH]) begin
        scan_found = 1'b1;
        scan_ch    = GW'((int'(grant_q) + i) % NUM_CH);
      end
    end
  end

  assign baud_end   = (baud_q == BAUD_LAST);
  assign frame_done = (state_q == ST_STOP) && baud_end && (bit_q == STOP_LAST);
  // A new packet may be granted from true idle, or right as a LAST byte completes.
  assign arb_free   = ((state_q == ST_IDLE) && !held_q && !pend_q) || (frame_done && last_q);
  assign start_new  = arb_free && scan_found;
  assign cont       = held_q && !last_q && !fifo_empty[grant_q] &&
                      (((state_q == ST_IDLE) && !pend_q) || frame_done);
  assign do_pop     = start_new || cont;
  assign pop_ch     = start_new ? scan_ch : grant_q;
  assign head       = fifo_head[pop_ch];

  // One-hot pop strobe toward the selected FIFO.
  always_comb begin
    pop_vec = '0;
    if (do_pop) pop_vec[pop_ch] = 1'b1;
  end

  // Serialiser state register.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) state_q <= ST_IDLE;
    else              state_q <= state_nxt;
  end

  // Serialiser next state; a pop from idle spends one cycle loading before START.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (pend_q) state_nxt = ST_START;
      ST_START:  if (baud_end) state_nxt = ST_DATA;
      ST_DATA:   if (baud_end && (bit_q == 3'd7))
                   state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_end) state_nxt = ST_STOP;
      ST_STOP:   if (frame_done) state_nxt = do_pop ? ST_START : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Line level for the coming cycle, so the registered TXD tracks the state exactly.
  always_comb begin
    txd_nxt = 1'b1;
    case (state_nxt)
      ST_START:  txd_nxt = 1'b0;
      ST_DATA:   txd_nxt = ((state_q == ST_DATA) && baud_end) ? shift_q[1] : shift_q[0];
      ST_PARITY: txd_nxt = par_q;
      default:   txd_nxt = 1'b1;
    endcase
  end

  // Control: baud/bit counters, grant ownership, load handshake and line register.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      baud_q  <= '0;
      bit_q   <= '0;
      grant_q <= GW'(NUM_CH - 1);
      held_q  <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      txd_q  <= txd_nxt;
      pend_q <= do_pop && (state_q == ST_IDLE);
      baud_q <= ((state_q == ST_IDLE) || baud_end) ? '0 : baud_q + 1'b1;
      if (baud_end && ((state_q == ST_DATA) || (state_q == ST_STOP)))
        bit_q <= ((state_q == ST_STOP) && (bit_q == STOP_LAST)) ? 3'd0 : bit_q + 3'd1;
      if (start_new) grant_q <= scan_ch;
      if (do_pop) begin
        held_q <= 1'b1;
        last_q <= head[ENTRY_W-1];
      end else if (frame_done && last_q) begin
        held_q <= 1'b0;
      end
    end
  end

  // Data: byte shifter and precomputed parity, loaded on every pop.
  always_ff @(posedge FAB_CLK) begin
    if (do_pop) begin
      shift_q <= head[7:0];
      par_q   <= parity_bit(head[7:0], PARITY);
    end else if ((state_q == ST_DATA) && baud_end) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign TXD   = txd_q;
  assign BUSY  = held_q || (state_q != ST_IDLE);
  assign GRANT = grant_q;
  assign FULL  = fifo_full;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_audio_uart_tx_arb.sv
// Directed bench: instance A (no parity, 1 stop, depth 4), B (even, 2 stops), C (odd).
module tb_audio_uart_tx_arb;

  localparam int CDIV = 4;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_bc_n;
  logic [1:0]  wr_en_a, wr_last_a, ovf_clr_a, full_a, ovf_a;
  logic [15:0] wr_data_a;
  logic        txd_a, busy_a;
  logic [0:0]  grant_a;
  logic [1:0]  wr_en_b, wr_en_c, wr_last_bc, ovf_clr_bc;
  logic [15:0] wr_data_bc;
  logic [1:0]  full_b, ovf_b, full_c, ovf_c;
  logic        txd_b, busy_b, txd_c, busy_c;
  logic [0:0]  grant_b, grant_c;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mon_sel = 0;
  logic txd_mon;

  always #5 clk = ~clk;

  always_comb begin
    txd_mon = txd_a;
    if (mon_sel == 1) txd_mon = txd_b;
    else if (mon_sel == 2) txd_mon = txd_c;
  end

  audio_uart_tx_arb #(.NUM_CH(2), .FIFO_DEPTH(4), .CLK_DIV(CDIV), .PARITY(0), .STOP_BITS(1)) u_a (
    .FAB_CLK(clk), .MSS_RESET_N(rst_a_n), .WR_EN(wr_en_a), .WR_DATA(wr_data_a),
    .WR_LAST(wr_last_a), .FULL(full_a), .OVF(ovf_a), .OVF_CLR(ovf_clr_a),
    .TXD(txd_a), .BUSY(busy_a), .GRANT(grant_a));

  audio_uart_tx_arb #(.NUM_CH(2), .FIFO_DEPTH(4), .CLK_DIV(CDIV), .PARITY(1), .STOP_BITS(2)) u_b (
    .FAB_CLK(clk), .MSS_RESET_N(rst_bc_n), .WR_EN(wr_en_b), .WR_DATA(wr_data_bc),
    .WR_LAST(wr_last_bc), .FULL(full_b), .OVF(ovf_b), .OVF_CLR(ovf_clr_bc),
    .TXD(txd_b), .BUSY(busy_b), .GRANT(grant_b));

  audio_uart_tx_arb #(.NUM_CH(2), .FIFO_DEPTH(4), .CLK_DIV(CDIV), .PARITY(2), .STOP_BITS(1)) u_c (
    .FAB_CLK(clk), .MSS_RESET_N(rst_bc_n), .WR_EN(wr_en_c), .WR_DATA(wr_data_bc),
    .WR_LAST(wr_last_bc), .FULL(full_c), .OVF(ovf_c), .OVF_CLR(ovf_clr_bc),
    .TXD(txd_c), .BUSY(busy_c), .GRANT(grant_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit on the monitored line, then samples each bit mid-cell.
  task automatic capture(input int npar, input int nstop, output logic [7:0] d,
                         output logic p, output logic sok, output int w);
    w = 0;
    while (txd_mon !== 1'b0 && w < 400) begin
      tick();
      w++;
    end
    check("frame_start_seen", 32'(w < 400), 32'd1);
    tick(); tick();
    check("frame_start_bit", 32'(txd_mon), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CDIV) tick();
      d[i] = txd_mon;
    end
    p = 1'b1;
    if (npar != 0) begin
      repeat (CDIV) tick();
      p = txd_mon;
    end
    sok = 1'b1;
    for (int s = 0; s < nstop; s++) begin
      repeat (CDIV) tick();
      if (txd_mon !== 1'b1) sok = 1'b0;
    end
  endtask

  logic [7:0] d;
  logic       p, sok;
  int         w;
  logic [9:0] fr;
  logic [7:0] pk_exp [4];
  logic [7:0] rr_exp [4];
  logic [7:0] c_exp  [4];

  initial begin
    rst_a_n = 1'b0; rst_bc_n = 1'b0;
    wr_en_a = '0; wr_last_a = '0; ovf_clr_a = '0; wr_data_a = '0;
    wr_en_b = '0; wr_en_c = '0; wr_last_bc = '0; ovf_clr_bc = '0; wr_data_bc = '0;
    repeat (3) tick();

    check("rst_txd_a",   32'(txd_a),   32'd1);
    check("rst_busy_a",  32'(busy_a),  32'd0);
    check("rst_grant_a", 32'(grant_a), 32'd1);
    check("rst_full_a",  32'(full_a),  32'd0);
    check("rst_ovf_a",   32'(ovf_a),   32'd0);
    check("rst_txd_b",   32'(txd_b),   32'd1);
    check("rst_busy_b",  32'(busy_b),  32'd0);
    check("rst_grant_b", 32'(grant_b), 32'd1);
    check("rst_flags_b", 32'({full_b, ovf_b}), 32'd0);
    check("rst_txd_c",   32'(txd_c),   32'd1);
    check("rst_grant_c", 32'(grant_c), 32'd1);
    check("rst_flags_c", 32'({full_c, ovf_c, busy_c}), 32'd0);
    rst_a_n = 1'b1; rst_bc_n = 1'b1;
    tick(); tick();

    // Single byte 0x55 on ch0, exact cycle timing
    wr_en_a = 2'b01; wr_data_a = 16'h0055; wr_last_a = 2'b01;
    tick();
    wr_en_a = '0; wr_last_a = '0;
    check("t1_busy_k", 32'(busy_a), 32'd0);
    tick();
    check("t1_busy_k1",  32'(busy_a),  32'd1);
    check("t1_grant_k1", 32'(grant_a), 32'd0);
    check("t1_txd_k1",   32'(txd_a),   32'd1);
    tick();
    check("t1_txd_k2", 32'(txd_a), 32'd0);
    fr = {1'b1, 8'h55, 1'b0};
    tick();
    for (int b = 1; b < 10; b++) begin
      repeat (CDIV) tick();
      check($sformatf("t1_bit%0d", b), 32'(txd_a), 32'(fr[b]));
    end
    tick(); tick();
    check("t1_busy_k41", 32'(busy_a), 32'd1);
    tick();
    check("t1_busy_k42", 32'(busy_a), 32'd0);
    check("t1_txd_k42",  32'(txd_a),  32'd1);

    // Even parity, two stop bits: 0x07 -> parity 1, 48-cycle frame
    mon_sel = 1;
    wr_en_b = 2'b01; wr_data_bc = 16'h0007; wr_last_bc = 2'b01;
    tick();
    wr_en_b = '0;
    capture(1, 2, d, p, sok, w);
    check("even_data", 32'(d), 32'h07);
    check("even_par",  32'(p), 32'd1);
    check("even_stop", 32'(sok), 32'd1);
    tick();
    check("even_busy_47", 32'(busy_b), 32'd1);
    tick();
    check("even_busy_48", 32'(busy_b), 32'd0);

    // Odd parity: 0x07 -> parity 0
    mon_sel = 2;
    wr_en_c = 2'b01;
    tick();
    wr_en_c = '0; wr_last_bc = '0;
    capture(1, 1, d, p, sok, w);
    check("odd_data", 32'(d), 32'h07);
    check("odd_par",  32'(p), 32'd0);
    check("odd_stop", 32'(sok), 32'd1);
    mon_sel = 0;

    // Packet hold: A1,A2,A3(LAST) on ch0 and B1(LAST) on ch1
    rst_a_n = 1'b0; tick(); rst_a_n = 1'b1; tick();
    pk_exp[0] = 8'hA1; pk_exp[1] = 8'hA2; pk_exp[2] = 8'hA3; pk_exp[3] = 8'hB1;
    wr_en_a = 2'b11; wr_data_a = 16'hB1A1; wr_last_a = 2'b10;
    tick();
    wr_en_a = 2'b01; wr_data_a = 16'h00A2; wr_last_a = 2'b00;
    tick();
    wr_data_a = 16'h00A3; wr_last_a = 2'b01;
    tick();
    wr_en_a = '0; wr_last_a = '0;
    for (int i = 0; i < 4; i++) begin
      capture(0, 1, d, p, sok, w);
      check($sformatf("pk_data%0d", i), 32'(d), 32'(pk_exp[i]));
      check($sformatf("pk_grant%0d", i), 32'(grant_a), (i == 3) ? 32'd1 : 32'd0);
      if (i > 0) check($sformatf("pk_gap%0d", i), 32'(w), 32'd2);
    end
    tick(); tick();
    check("pk_busy_end", 32'(busy_a), 32'd0);

    // Round robin: single-byte packets queued on both channels
    rr_exp[0] = 8'h31; rr_exp[1] = 8'h41; rr_exp[2] = 8'h32; rr_exp[3] = 8'h42;
    wr_en_a = 2'b11; wr_last_a = 2'b11; wr_data_a = 16'h4131;
    tick();
    wr_data_a = 16'h4232;
    tick();
    wr_en_a = '0; wr_last_a = '0;
    for (int i = 0; i < 4; i++) begin
      capture(0, 1, d, p, sok, w);
      check($sformatf("rr_data%0d", i), 32'(d), 32'(rr_exp[i]));
      check($sformatf("rr_grant%0d", i), 32'(grant_a), 32'(i % 2));
    end

    // Overflow: ch0 holds the grant mid-packet while ch1 fills
    c_exp[0] = 8'h11; c_exp[1] = 8'h22; c_exp[2] = 8'h33; c_exp[3] = 8'h44;
    tick(); tick();
    wr_en_a = 2'b01; wr_data_a = 16'h005A; wr_last_a = 2'b00;
    tick();
    wr_en_a = 2'b10; wr_last_a = 2'b10;
    wr_data_a = 16'h1100; tick();
    wr_data_a = 16'h2200; tick();
    wr_data_a = 16'h3300; tick();
    check("ovf_full_after3", 32'(full_a[1]), 32'd0);
    wr_data_a = 16'h4400; tick();
    check("ovf_full_after4", 32'(full_a[1]), 32'd1);
    check("ovf_flag_after4", 32'(ovf_a[1]), 32'd0);
    wr_data_a = 16'h9900; tick();
    check("ovf_flag_after5", 32'(ovf_a[1]), 32'd1);
    wr_data_a = 16'h7700; ovf_clr_a = 2'b10; tick();
    check("ovf_set_wins", 32'(ovf_a[1]), 32'd1);
    wr_en_a = '0; wr_last_a = '0; tick();
    check("ovf_cleared", 32'(ovf_a), 32'd0);
    ovf_clr_a = '0;
    repeat (50) tick();
    check("stall_busy",  32'(busy_a),  32'd1);
    check("stall_txd",   32'(txd_a),   32'd1);
    check("stall_grant", 32'(grant_a), 32'd0);
    wr_en_a = 2'b01; wr_data_a = 16'h00A5; wr_last_a = 2'b01;
    tick();
    wr_en_a = '0; wr_last_a = '0;
    capture(0, 1, d, p, sok, w);
    check("stall_tail_data", 32'(d), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      capture(0, 1, d, p, sok, w);
      check($sformatf("ovf_data%0d", i), 32'(d), 32'(c_exp[i]));
      check($sformatf("ovf_gap%0d", i), 32'(w), 32'd2);
      check($sformatf("ovf_grant%0d", i), 32'(grant_a), 32'd1);
      if (i == 0) check("ovf_full_after_pop", 32'(full_a[1]), 32'd0);
    end
    tick(); tick();
    check("ovf_busy_end", 32'(busy_a), 32'd0);
    repeat (60) tick();
    check("ovf_no_fifth_txd",  32'(txd_a),  32'd1);
    check("ovf_no_fifth_busy", 32'(busy_a), 32'd0);

    // Reset in the middle of a DATA bit, with a second byte queued
    wr_en_a = 2'b11; wr_data_a = 16'h0FF0; wr_last_a = 2'b11;
    tick();
    wr_en_a = '0; wr_last_a = '0;
    repeat (12) tick();
    check("mid_txd_low", 32'(txd_a), 32'd0);
    rst_a_n = 1'b0;
    #1;
    check("mid_rst_txd",   32'(txd_a),   32'd1);
    check("mid_rst_busy",  32'(busy_a),  32'd0);
    check("mid_rst_grant", 32'(grant_a), 32'd1);
    check("mid_rst_full",  32'(full_a),  32'd0);
    tick();
    rst_a_n = 1'b1;
    tick();
    wr_en_a = 2'b01; wr_data_a = 16'h003C; wr_last_a = 2'b01;
    tick();
    wr_en_a = '0; wr_last_a = '0;
    capture(0, 1, d, p, sok, w);
    check("post_rst_data", 32'(d), 32'h3C);
    check("post_rst_stop", 32'(sok), 32'd1);
    tick(); tick();
    check("post_rst_busy", 32'(busy_a), 32'd0);
    repeat (60) tick();
    check("post_rst_quiet_txd",  32'(txd_a),  32'd1);
    check("post_rst_quiet_busy", 32'(busy_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
